// File: rtl/trig_link_pkg.sv
// Shared trigger-link definitions: K-character codes, frame geometry,
// receiver FSM states and the reassembled cluster payload record.
package trig_link_pkg;

    localparam int unsigned WORD_W          = 16;
    localparam int unsigned WORDS_PER_FRAME = 4;
    localparam int unsigned PAYLOAD_W       = 56;

    localparam logic [7:0] K_IDLE   = 8'hBC;  // K28.5, normal frame
    localparam logic [7:0] K_BC0    = 8'h3C;  // K28.1, bunch-crossing zero
    localparam logic [7:0] K_RESYNC = 8'hF7;  // K23.7, resync

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] data;
        logic                 bc0;
        logic                 resync;
    } gem_frame_t;

    // A legal frame-start word: low byte is K, high byte is data, K byte is a known code.
    function automatic logic is_w0_word(input logic [WORD_W-1:0] d, input logic [1:0] k);
        return (k == 2'b01) &&
               ((d[7:0] == K_IDLE) || (d[7:0] == K_BC0) || (d[7:0] == K_RESYNC));
    endfunction

endpackage

// File: rtl/bc0_period_chk.sv
// BC0 spacing checker: counts valid frames between BC0 markers and flags a
// BC0 whose spacing differs from BX_PER_ORBIT. The first BC0 after lock only
// arms the check.
// Ports: clk_160, reset (sync, active high); frame_valid/frame_bc0 describe the
// frame being emitted this cycle; locked is the receiver lock state;
// bc0_err_o is registered so it lines up with the receiver's valid strobe.
module bc0_period_chk #(
    parameter int unsigned BX_PER_ORBIT = 3564
) (
    input  logic clk_160,
    input  logic reset,
    input  logic frame_valid,
    input  logic frame_bc0,
    input  logic locked,
    output logic bc0_err_o
);

    localparam int unsigned CNT_W = $clog2(BX_PER_ORBIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;

    // cnt_q holds the spacing the next BC0 would have; saturates so a long gap stays an error.
    always_ff @(posedge clk_160) begin
        if (reset) begin
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            bc0_err_o <= 1'b0;
        end else begin
            bc0_err_o <= 1'b0;
            if (!locked) begin
                cnt_q   <= '0;
                armed_q <= 1'b0;
            end else if (frame_valid) begin
                if (frame_bc0) begin
                    bc0_err_o <= armed_q && (cnt_q != CNT_W'(BX_PER_ORBIT));
                    cnt_q     <= CNT_W'(1);
                    armed_q   <= 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mgt_frame_rx.sv
// Trigger-link frame receiver: aligns 4-word frames on the 16-bit MGT word
// stream, tracks lock with HUNT/SYNC/LOCKED, and emits the 56-bit cluster
// payload with a one-cycle valid strobe for every good frame while locked.
// Ports: clk_160, reset (sync, active high); rx_data_i/rx_isk_i word and
// K flags; gem_data_o/bc0_o/resync_o frame contents qualified by valid_o;
// locked_o lock state; err_cnt_o saturating bad-frame count while locked;
// bc0_err_o BC0 spacing violation strobe.
// Build option: define MGT_FRAME_RX_BC0_CHECK_EN to include the BC0 spacing
// checker; otherwise bc0_err_o is constant 0.
module mgt_frame_rx
    import trig_link_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES   = 4,
    parameter int unsigned UNLOCK_FRAMES = 2,
    parameter int unsigned BX_PER_ORBIT  = 3564
) (
    input  logic                 clk_160,
    input  logic                 reset,
    input  logic [WORD_W-1:0]    rx_data_i,
    input  logic [1:0]           rx_isk_i,
    output logic [PAYLOAD_W-1:0] gem_data_o,
    output logic                 valid_o,
    output logic                 bc0_o,
    output logic                 resync_o,
    output logic                 locked_o,
    output logic [15:0]          err_cnt_o,
    output logic                 bc0_err_o
);

    localparam int unsigned WCNT_W = $clog2(WORDS_PER_FRAME);
    localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_FRAMES + 1);

    rx_state_e          state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic               frame_bad_q, frame_bad_d;
    logic [7:0]         w0_hi_q, w0_hi_d;
    logic [7:0]         w0_k_q, w0_k_d;
    logic [WORD_W-1:0]  w1_q, w1_d;
    logic [WORD_W-1:0]  w2_q, w2_d;
    logic [15:0]        err_q, err_d;
    logic               valid_q;
    logic               locked_q;
    gem_frame_t         out_q;

    logic               w0_ok_c;
    logic               wn_ok_c;
    logic               last_bad_c;
    logic               emit_c;

    assign w0_ok_c    = is_w0_word(rx_data_i, rx_isk_i);
    assign wn_ok_c    = (rx_isk_i == 2'b00);
    assign last_bad_c = frame_bad_q | ~wn_ok_c;

    // Next-state: frame verdict is taken when w3 is sampled.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        good_d      = good_q;
        bad_d       = bad_q;
        frame_bad_d = frame_bad_q;
        w0_hi_d     = w0_hi_q;
        w0_k_d      = w0_k_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        err_d       = err_q;
        emit_c      = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (w0_ok_c) begin
                    state_d     = ST_SYNC;
                    wcnt_d      = WCNT_W'(1);
                    good_d      = '0;
                    frame_bad_d = 1'b0;
                    w0_hi_d     = rx_data_i[15:8];
                    w0_k_d      = rx_data_i[7:0];
                end
            end
            ST_SYNC, ST_LOCKED: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                case (wcnt_q)
                    WCNT_W'(0): begin
                        frame_bad_d = ~w0_ok_c;
                        w0_hi_d     = rx_data_i[15:8];
                        w0_k_d      = rx_data_i[7:0];
                    end
                    WCNT_W'(1): begin
                        frame_bad_d = frame_bad_q | ~wn_ok_c;
                        w1_d        = rx_data_i;
                    end
                    WCNT_W'(2): begin
                        frame_bad_d = frame_bad_q | ~wn_ok_c;
                        w2_d        = rx_data_i;
                    end
                    default: begin
                        frame_bad_d = 1'b0;
                        if (state_q == ST_SYNC) begin
                            if (last_bad_c) begin
                                state_d = ST_HUNT;
                            end else if (good_q == GOOD_W'(LOCK_FRAMES - 1)) begin
                                state_d = ST_LOCKED;
                                bad_d   = '0;
                            end else begin
                                good_d = good_q + GOOD_W'(1);
                            end
                        end else if (last_bad_c) begin
                            if (err_q != 16'hFFFF) begin
                                err_d = err_q + 16'd1;
                            end
                            if (bad_q == BAD_W'(UNLOCK_FRAMES - 1)) begin
                                state_d = ST_HUNT;
                            end else begin
                                bad_d = bad_q + BAD_W'(1);
                            end
                        end else begin
                            bad_d  = '0;
                            emit_c = 1'b1;
                        end
                    end
                endcase
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // State, frame buffer and registered outputs.
    always_ff @(posedge clk_160) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            wcnt_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            frame_bad_q <= 1'b0;
            w0_hi_q     <= '0;
            w0_k_q      <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            err_q       <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            frame_bad_q <= frame_bad_d;
            w0_hi_q     <= w0_hi_d;
            w0_k_q      <= w0_k_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            err_q       <= err_d;
            valid_q     <= emit_c;
            locked_q    <= (state_d == ST_LOCKED);
            if (emit_c) begin
                out_q.data   <= {rx_data_i, w2_q, w1_q, w0_hi_q};
                out_q.bc0    <= (w0_k_q == K_BC0);
                out_q.resync <= (w0_k_q == K_RESYNC);
            end
        end
    end

    assign gem_data_o = out_q.data;
    assign bc0_o      = out_q.bc0;
    assign resync_o   = out_q.resync;
    assign valid_o    = valid_q;
    assign locked_o   = locked_q;
    assign err_cnt_o  = err_q;

`ifdef MGT_FRAME_RX_BC0_CHECK_EN
    bc0_period_chk #(
        .BX_PER_ORBIT (BX_PER_ORBIT)
    ) u_bc0_chk (
        .clk_160     (clk_160),
        .reset       (reset),
        .frame_valid (emit_c),
        .frame_bc0   (w0_k_q == K_BC0),
        .locked      (state_q == ST_LOCKED),
        .bc0_err_o   (bc0_err_o)
    );
`else
    assign bc0_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mgt_frame_rx.sv
// Bench for mgt_frame_rx: directed frame table, misaligned start, mid-frame
// reset, BC0 spacing (when MGT_FRAME_RX_BC0_CHECK_EN is defined) and random
// frames checked against a frame-level model of the lock rules.
module tb_mgt_frame_rx;
    import trig_link_pkg::*;

    localparam int unsigned LOCK_FRAMES   = 4;
    localparam int unsigned UNLOCK_FRAMES = 2;
    localparam int unsigned BX            = 3564;

    logic        clk_160 = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] rx_data = '0;
    logic [1:0]  rx_isk  = '0;
    logic [55:0] gem_data_o;
    logic        valid_o, bc0_o, resync_o, locked_o, bc0_err_o;
    logic [15:0] err_cnt_o;

    mgt_frame_rx #(
        .LOCK_FRAMES   (LOCK_FRAMES),
        .UNLOCK_FRAMES (UNLOCK_FRAMES),
        .BX_PER_ORBIT  (BX)
    ) dut (
        .clk_160    (clk_160),
        .reset      (reset),
        .rx_data_i  (rx_data),
        .rx_isk_i   (rx_isk),
        .gem_data_o (gem_data_o),
        .valid_o    (valid_o),
        .bc0_o      (bc0_o),
        .resync_o   (resync_o),
        .locked_o   (locked_o),
        .err_cnt_o  (err_cnt_o),
        .bc0_err_o  (bc0_err_o)
    );

    always #5 clk_160 = ~clk_160;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          valid_seen = 0;
    int          valid_exp  = 0;
    logic [55:0] last_payload = '0;

    // Every valid_o pulse in the run must be one the bench asked for.
    always @(posedge clk_160) begin
        #1;
        if (valid_o) valid_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic [1:0] k);
        @(negedge clk_160);
        rx_data = d;
        rx_isk  = k;
    endtask

    task automatic do_reset();
        @(negedge clk_160);
        reset   = 1'b1;
        rx_data = '0;
        rx_isk  = '0;
        @(posedge clk_160);
        #1;
        check("reset gem_data", gem_data_o, 0);
        check("reset valid",    valid_o,    0);
        check("reset bc0",      bc0_o,      0);
        check("reset resync",   resync_o,   0);
        check("reset locked",   locked_o,   0);
        check("reset err_cnt",  err_cnt_o,  0);
        check("reset bc0_err",  bc0_err_o,  0);
        @(negedge clk_160);
        reset = 1'b0;
        last_payload = '0;
    endtask

    // bad_w: -1 clean, 0 corrupt w0 (isk 00), 1..3 corrupt wN (isk 01, non-K byte).
    task automatic frame_chk(input string tag, input logic [7:0] kchar, input int bad_w,
                             input logic ev, input logic el, input logic [15:0] ee,
                             input logic eb);
        logic [15:0] w [4];
        logic [1:0]  k [4];
        logic [55:0] pay;
        w[0] = {8'($urandom), kchar};
        k[0] = 2'b01;
        for (int i = 1; i < 4; i++) begin
            w[i] = 16'($urandom);
            k[i] = 2'b00;
        end
        if (bad_w == 0) begin
            k[0] = 2'b00;
        end else if (bad_w > 0) begin
            k[bad_w]      = 2'b01;
            w[bad_w][7:0] = 8'h00;
        end
        for (int i = 0; i < 4; i++) send_word(w[i], k[i]);
        @(posedge clk_160);
        #1;
        pay = {w[3], w[2], w[1], w[0][15:8]};
        check({tag, " valid"},   valid_o,   ev);
        check({tag, " locked"},  locked_o,  el);
        check({tag, " err_cnt"}, err_cnt_o, ee);
        check({tag, " bc0_err"}, bc0_err_o, eb);
        if (ev) begin
            check({tag, " payload"}, gem_data_o, pay);
            check({tag, " bc0"},     bc0_o,      kchar == K_BC0);
            check({tag, " resync"},  resync_o,   kchar == K_RESYNC);
            last_payload = pay;
            valid_exp++;
        end else begin
            check({tag, " hold"}, gem_data_o, last_payload);
        end
    endtask

    typedef struct {
        logic        pre_reset;
        logic [7:0]  kchar;
        int          bad_w;
        logic        ev;
        logic        el;
        logic [15:0] ee;
    } vec_t;

    function automatic vec_t mk(input logic pr, input logic [7:0] kc, input int bw,
                                input logic ev, input logic el, input logic [15:0] ee);
        vec_t v;
        v.pre_reset = pr;
        v.kchar     = kc;
        v.bad_w     = bw;
        v.ev        = ev;
        v.el        = el;
        v.ee        = ee;
        return v;
    endfunction

    initial begin
        vec_t tbl [19];
        // frame-level reference model state
        int   st, good, badrun, armed, bcnt;
        logic [15:0] err;
        logic [7:0]  kc;
        int   bw;
        logic fb, ev, eb;

        // lock, single error, reset/relock, loss of lock, relock, BC0, resync
        tbl[0]  = mk(0, K_IDLE,   -1, 0, 0, 0);
        tbl[1]  = mk(0, K_IDLE,   -1, 0, 0, 0);
        tbl[2]  = mk(0, K_IDLE,   -1, 0, 0, 0);
        tbl[3]  = mk(0, K_IDLE,   -1, 0, 1, 0);
        tbl[4]  = mk(0, K_IDLE,   -1, 1, 1, 0);
        tbl[5]  = mk(0, K_IDLE,    2, 0, 1, 1);
        tbl[6]  = mk(0, K_IDLE,   -1, 1, 1, 1);
        tbl[7]  = mk(1, K_IDLE,   -1, 0, 0, 0);
        tbl[8]  = mk(0, K_IDLE,   -1, 0, 0, 0);
        tbl[9]  = mk(0, K_IDLE,   -1, 0, 0, 0);
        tbl[10] = mk(0, K_IDLE,   -1, 0, 1, 0);
        tbl[11] = mk(0, K_IDLE,    2, 0, 1, 1);
        tbl[12] = mk(0, K_IDLE,    2, 0, 0, 2);
        tbl[13] = mk(0, K_IDLE,   -1, 0, 0, 2);
        tbl[14] = mk(0, K_IDLE,   -1, 0, 0, 2);
        tbl[15] = mk(0, K_IDLE,   -1, 0, 0, 2);
        tbl[16] = mk(0, K_IDLE,   -1, 0, 1, 2);
        tbl[17] = mk(0, K_BC0,    -1, 1, 1, 2);
        tbl[18] = mk(0, K_RESYNC, -1, 1, 1, 2);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].pre_reset) do_reset();
            frame_chk($sformatf("tbl%0d", i), tbl[i].kchar, tbl[i].bad_w,
                      tbl[i].ev, tbl[i].el, tbl[i].ee, 1'b0);
        end

        // misaligned start: two junk data words before the first frame
        do_reset();
        send_word(16'($urandom), 2'b00);
        send_word(16'($urandom), 2'b00);
        for (int i = 0; i < 4; i++)
            frame_chk($sformatf("misalign%0d", i), K_IDLE, -1, 1'b0, i == 3, 16'd0, 1'b0);
        frame_chk("misalign4", K_IDLE, -1, 1'b1, 1'b1, 16'd0, 1'b0);

        // reset in the middle of a frame while locked
        send_word({8'hA5, K_IDLE}, 2'b01);
        send_word(16'h1234, 2'b00);
        check("midreset pre locked", locked_o, 1);
        do_reset();
        frame_chk("post_reset", K_IDLE, -1, 1'b0, 1'b0, 16'd0, 1'b0);

`ifdef MGT_FRAME_RX_BC0_CHECK_EN
        // BC0 spacing: first exempt, then exactly BX, then BX-1
        do_reset();
        for (int i = 0; i < 4; i++)
            frame_chk("bc0 lock", K_IDLE, -1, 1'b0, i == 3, 16'd0, 1'b0);
        frame_chk("bc0 first", K_BC0, -1, 1'b1, 1'b1, 16'd0, 1'b0);
        for (int i = 0; i < int'(BX) - 1; i++)
            frame_chk("bc0 gap1", K_IDLE, -1, 1'b1, 1'b1, 16'd0, 1'b0);
        frame_chk("bc0 on_time", K_BC0, -1, 1'b1, 1'b1, 16'd0, 1'b0);
        for (int i = 0; i < int'(BX) - 2; i++)
            frame_chk("bc0 gap2", K_IDLE, -1, 1'b1, 1'b1, 16'd0, 1'b0);
        frame_chk("bc0 early", K_BC0, -1, 1'b1, 1'b1, 16'd0, 1'b1);
`endif

        // random frames against the frame-level lock model
        do_reset();
        st = 0; good = 0; badrun = 0; armed = 0; bcnt = 0; err = '0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       kc = K_BC0;
                1:       kc = K_RESYNC;
                default: kc = K_IDLE;
            endcase
            bw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            fb = (bw >= 0);
            ev = 1'b0;
            eb = 1'b0;
            if (st == 0) begin
                if (bw != 0 && !fb) begin
                    good = 1;
                    st   = (good >= int'(LOCK_FRAMES)) ? 2 : 1;
                    badrun = 0;
                end
            end else if (st == 1) begin
                if (fb) begin
                    st = 0;
                end else begin
                    good++;
                    if (good >= int'(LOCK_FRAMES)) begin
                        st = 2;
                        badrun = 0;
                    end
                end
            end else begin
                if (fb) begin
                    if (err != 16'hFFFF) err++;
                    badrun++;
                    if (badrun >= int'(UNLOCK_FRAMES)) st = 0;
                end else begin
                    badrun = 0;
                    ev = 1'b1;
                    if (kc == K_BC0) begin
                        eb    = (armed != 0) && (bcnt != int'(BX));
                        bcnt  = 1;
                        armed = 1;
                    end else begin
                        bcnt++;
                    end
                end
            end
            if (st != 2) begin
                armed = 0;
                bcnt  = 0;
            end
`ifndef MGT_FRAME_RX_BC0_CHECK_EN
            eb = 1'b0;
`endif
            frame_chk($sformatf("rand%0d", n), kc, bw, ev, st == 2, err, eb);
        end

        repeat (3) @(posedge clk_160);
        #2;
        check("valid pulse count", 64'(valid_seen), 64'(valid_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
